// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rasterises one clipped, filled rectangle per accepted command,
// emitting one pixel per clock in row-major order towards vga_adapter.
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x,
  input  logic [Y_W-1:0]      cmd_y,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Screen limits widened by one bit so size arithmetic never wraps.
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t                state;
  logic [X_W-1:0]        cx;
  logic [Y_W-1:0]        cy;
  logic [X_W-1:0]        x0;
  logic [Y_W-1:0]        y0;
  logic [COLOUR_W-1:0]   colour;
  logic [X_W-1:0]        w_last;   // clipped width minus one
  logic [Y_W-1:0]        h_last;   // clipped height minus one

  logic [X_W:0]          room_x;
  logic [Y_W:0]          room_y;
  logic [X_W:0]          clip_w;
  logic [Y_W:0]          clip_h;
  logic                  empty_cmd;

  // Clip the incoming size against the space left between the origin and the screen edge.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    room_x    = SCR_W - {1'b0, cmd_x};
    room_y    = SCR_H - {1'b0, cmd_y};
    clip_w    = ({1'b0, cmd_w} < room_x) ? {1'b0, cmd_w} : room_x;
    clip_h    = ({1'b0, cmd_h} < room_y) ? {1'b0, cmd_h} : room_y;
    empty_cmd = (cmd_w == '0) || (cmd_h == '0) ||
                ({1'b0, cmd_x} >= SCR_W) || ({1'b0, cmd_y} >= SCR_H);
  end

  // Command FSM and raster counters.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cx     <= '0;
      cy     <= '0;
      x0     <= '0;
      y0     <= '0;
      colour <= '0;
      w_last <= '0;
      h_last <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x0     <= cmd_x;
            y0     <= cmd_y;
            colour <= cmd_colour;
            w_last <= X_W'(clip_w - 1'b1);
            h_last <= Y_W'(clip_h - 1'b1);
            state  <= empty_cmd ? DONE : DRAW;
          end
        end
        DRAW: begin
          if (cx == w_last) begin
            cx <= '0;
            if (cy == h_last) begin
              cy    <= '0;
              state <= DONE;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decodes; reset forces every output low immediately, including mid-DRAW.
  // Counters are zero outside DRAW, so x0+cx / y0+cy hold the last origin there.
  assign cmd_ready  = !reset && (state == IDLE);
  assign plot       = !reset && (state == DRAW);
  assign busy       = !reset && ((state == DRAW) || (state == DONE));
  assign done       = !reset && (state == DONE);
  assign x_out      = reset ? '0 : x0 + cx;
  assign y_out      = reset ? '0 : y0 + cy;
  assign colour_out = reset ? '0 : colour;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: the driver queues expected pixels and done
// markers; a monitor pops and compares whenever plot or done is presented.
module tb_rect_fill_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x = '0;
  logic [6:0] cmd_y = '0;
  logic [7:0] cmd_w = '0;
  logic [6:0] cmd_h = '0;
  logic [2:0] cmd_colour = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  rect_fill_engine dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   max_x    = 0;
  int   max_y    = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare every presented pixel / done pulse against the head of the queue.
  always @(negedge clock) begin
    exp_t e;
    if (plot === 1'b1 || done === 1'b1) begin
      if (plot === 1'b1) begin
        if (int'(x_out) > max_x) max_x = int'(x_out);
        if (int'(y_out) > max_y) max_y = int'(y_out);
      end
      check("plot_done_exclusive", {31'd0, plot & done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_output", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_done", {31'd0, done}, {31'd0, e.is_done});
        if (!e.is_done) begin
          check("pixel_x", {24'd0, x_out}, {24'd0, e.x});
          check("pixel_y", {25'd0, y_out}, {25'd0, e.y});
          check("pixel_colour", {29'd0, colour_out}, {29'd0, e.col});
        end
      end
    end
  end

  // Reference: walk the unclipped rectangle and keep only on-screen pixels.
  task automatic push_cmd(input int x, input int y, input int w, input int h,
                          input int col, output int n);
    exp_t e;
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if ((x + c) < 160 && (y + r) < 120) begin
          e.is_done = 1'b0;
          e.x       = 8'(x + c);
          e.y       = 7'(y + r);
          e.col     = 3'(col);
          exp_q.push_back(e);
          n++;
        end
      end
    end
    e = '0;
    e.is_done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Drive a command (called just after a falling edge) and return once it is accepted.
  task automatic handshake(input int x, input int y, input int w, input int h, input int col);
    bit got;
    cmd_x      = 8'(x);
    cmd_y      = 7'(y);
    cmd_w      = 8'(w);
    cmd_h      = 7'(h);
    cmd_colour = 3'(col);
    cmd_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    check("ready_seen", {31'd0, got}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  // Count cycles after acceptance: first plot in cycle 1, done in cycle n+1, ready in n+2.
  task automatic wait_done(input int n);
    bit got;
    got = 1'b0;
    for (int k = 1; k <= n + 20; k++) begin
      @(negedge clock);
      if (k == 1 && n > 0) check("first_plot_latency", {31'd0, plot}, 32'd1);
      if (done === 1'b1) begin
        check("done_cycle", k, n + 1);
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    @(negedge clock);
    check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    #1;
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h, input int col);
    int n;
    push_cmd(x, y, w, h, col, n);
    handshake(x, y, w, h, col);
    cmd_valid = 1'b0;
    wait_done(n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_plot"}, {31'd0, plot}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
    check({tag, "_x"}, {24'd0, x_out}, 32'd0);
    check({tag, "_y"}, {25'd0, y_out}, 32'd0);
    check({tag, "_colour"}, {29'd0, colour_out}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Power-on reset.
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    #1 reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    #1;

    // 1: basic 4x4 fill; afterwards outputs hold the origin and colour.
    run_cmd(10, 20, 4, 4, 3'b100);
    check("hold_x", {24'd0, x_out}, 32'd10);
    check("hold_y", {25'd0, y_out}, 32'd20);
    check("hold_colour", {29'd0, colour_out}, 32'd4);

    // 2: clipped at the bottom-right corner -> 4 pixels.
    run_cmd(158, 118, 4, 4, 3'b011);

    // 3: empty commands.
    run_cmd(5, 5, 0, 5, 3'b001);
    run_cmd(160, 5, 3, 3, 3'b001);
    run_cmd(5, 120, 3, 3, 3'b001);

    // 4: oversized full-screen fill.
    max_x = 0;
    max_y = 0;
    run_cmd(0, 0, 255, 127, 3'b111);
    check("full_max_x", max_x, 159);
    check("full_max_y", max_y, 119);

    // 5: reset after the 5th plot of a 4x4.
    push_cmd(30, 40, 4, 4, 3'b101, n);
    for (int i = 0; i < 12; i++) void'(exp_q.pop_back());  // drop pixels 6..16 and done
    handshake(30, 40, 4, 4, 3'b101);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_all_zero("abort");
    #1 reset = 1'b0;
    @(negedge clock);
    check("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
    check("abort_queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clock);
    #1;

    // 6: second command held valid during the first one's DRAW.
    push_cmd(50, 60, 3, 2, 3'b110, n);
    begin
      int n2;
      push_cmd(0, 0, 1, 1, 3'b010, n2);
    end
    handshake(50, 60, 3, 2, 3'b110);
    cmd_x      = 8'd0;
    cmd_y      = 7'd0;
    cmd_w      = 8'd1;
    cmd_h      = 7'd1;
    cmd_colour = 3'b010;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clock);
      check("b2b_ready_low", {31'd0, cmd_ready}, 32'd0);
      if (k == n + 1) check("b2b_done", {31'd0, done}, 32'd1);
    end
    @(negedge clock);
    check("b2b_ready_back", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    wait_done(1);

    repeat (5) @(negedge clock);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
